pipeline_hazard_ctrl: RTL and testbench

- Sequences the five-stage pipeline by driving the enable/flush pair of each pipeline register (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC enable.
- Resolves instruction-fetch misses, data-memory waits, load-use hazards, taken branches resolved in MEM, and halt drain.
- Gates the instruction-memory request while a data access is outstanding, giving data priority on the shared memory port.
- Sits beside the datapath and consumes EX/MEM and ID/EX register outputs.

---
 rtl/pipeline_hazard_ctrl.sv | 177 +++++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and sequencing controller for a five-stage pipeline: drives PC enable and the
// enable/flush pair of every pipeline register, arbitrates the shared memory port, and drains on halt.
module pipeline_hazard_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             dmemREN,
  input  logic             dmemWEN,
  input  logic             halt_EX_MEM,
  input  logic             branch_taken_EX_MEM,
  input  logic             dREN_ID_EX,
  input  logic [4:0]       Rt_ID_EX,
  input  logic [4:0]       Rs_IF_ID,
  input  logic [4:0]       Rt_IF_ID,
  output logic             enable_PC,
  output logic             enable_IF_ID,
  output logic             flush_IF_ID,
  output logic             enable_ID_EX,
  output logic             flush_ID_EX,
  output logic             enable_EX_MEM,
  output logic             flush_EX_MEM,
  output logic             enable_MEM_WB,
  output logic             flush_MEM_WB,
  output logic             imemREN_gate,
  output logic             halt,
  output logic [CNT_W-1:0] stall_cycles
);

  // state  | meaning
  // RUN    | normal issue; resolves halt, data miss, branch, load-use, fetch miss
  // DWAIT  | data access outstanding; pipeline frozen, fetch request withheld
  // DRAIN  | one cycle letting the MEM-stage instruction retire before halting
  // HALTED | everything frozen and flushed until reset
  typedef enum logic [1:0] {RUN, DWAIT, DRAIN, HALTED} state_t;

  state_t             state_q, state_d;
  logic               halt_q, halt_d;
  logic [CNT_W-1:0]   stall_q, stall_d;

  logic dmem_req;
  logic load_use;

  assign dmem_req = dmemREN | dmemWEN;
  assign load_use = dREN_ID_EX && (Rt_ID_EX != 5'd0) &&
                    ((Rt_ID_EX == Rs_IF_ID) || (Rt_ID_EX == Rt_IF_ID));

  always_comb begin
    state_d       = state_q;
    enable_PC     = 1'b1;
    enable_IF_ID  = 1'b1;
    flush_IF_ID   = 1'b0;
    enable_ID_EX  = 1'b1;
    flush_ID_EX   = 1'b0;
    enable_EX_MEM = 1'b1;
    flush_EX_MEM  = 1'b0;
    enable_MEM_WB = 1'b1;
    flush_MEM_WB  = 1'b0;
    imemREN_gate  = 1'b1;

    case (state_q)
      RUN: begin
        if (halt_EX_MEM) begin
          enable_PC    = 1'b0;
          flush_IF_ID  = 1'b1;
          flush_ID_EX  = 1'b1;
          flush_EX_MEM = 1'b1;
          state_d      = DRAIN;
        end else if (dmem_req && !dhit) begin
          enable_PC     = 1'b0;
          enable_IF_ID  = 1'b0;
          enable_ID_EX  = 1'b0;
          enable_EX_MEM = 1'b0;
          enable_MEM_WB = 1'b0;
          flush_MEM_WB  = 1'b1;
          imemREN_gate  = 1'b0;
          state_d       = DWAIT;
        end else if (branch_taken_EX_MEM && ihit) begin
          flush_IF_ID  = 1'b1;
          flush_ID_EX  = 1'b1;
          flush_EX_MEM = 1'b1;
        end else if (branch_taken_EX_MEM) begin
          // Hold the branch in MEM until the target fetch returns; bubble WB so it retires once.
          enable_PC     = 1'b0;
          enable_IF_ID  = 1'b0;
          flush_ID_EX   = 1'b1;
          enable_EX_MEM = 1'b0;
          flush_MEM_WB  = 1'b1;
        end else if (load_use || !ihit) begin
          enable_PC    = 1'b0;
          enable_IF_ID = 1'b0;
          flush_ID_EX  = 1'b1;
        end
      end

      DWAIT: begin
        imemREN_gate = 1'b0;
        enable_PC    = 1'b0;
        enable_IF_ID = 1'b0;
        enable_ID_EX = 1'b0;
        if (dhit) begin
          flush_EX_MEM = 1'b1;
          state_d      = RUN;
        end else begin
          enable_EX_MEM = 1'b0;
          enable_MEM_WB = 1'b0;
          flush_MEM_WB  = 1'b1;
        end
      end

      DRAIN: begin
        imemREN_gate  = 1'b0;
        enable_PC     = 1'b0;
        enable_IF_ID  = 1'b0;
        enable_ID_EX  = 1'b0;
        enable_EX_MEM = 1'b0;
        flush_IF_ID   = 1'b1;
        flush_ID_EX   = 1'b1;
        flush_EX_MEM  = 1'b1;
        state_d       = HALTED;
      end

      default: begin
        imemREN_gate  = 1'b0;
        enable_PC     = 1'b0;
        enable_IF_ID  = 1'b0;
        enable_ID_EX  = 1'b0;
        enable_EX_MEM = 1'b0;
        enable_MEM_WB = 1'b0;
        flush_IF_ID   = 1'b1;
        flush_ID_EX   = 1'b1;
        flush_EX_MEM  = 1'b1;
        flush_MEM_WB  = 1'b1;
      end
    endcase

    // Reset must freeze and flush every stage without waiting for a clock edge.
    if (!nRST) begin
      enable_PC     = 1'b0;
      enable_IF_ID  = 1'b0;
      enable_ID_EX  = 1'b0;
      enable_EX_MEM = 1'b0;
      enable_MEM_WB = 1'b0;
      flush_IF_ID   = 1'b1;
      flush_ID_EX   = 1'b1;
      flush_EX_MEM  = 1'b1;
      flush_MEM_WB  = 1'b1;
      imemREN_gate  = 1'b0;
    end
  end

  always_comb begin
    halt_d  = halt_q | (state_q == DRAIN);
    stall_d = stall_q;
    if (!enable_PC && (state_q != HALTED) && (stall_q != {CNT_W{1'b1}})) begin
      stall_d = stall_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= RUN;
      halt_q  <= 1'b0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      halt_q  <= halt_d;
      stall_q <= stall_d;
    end
  end

  assign halt         = halt_q;
  assign stall_cycles = stall_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed plus randomized bench for pipeline_hazard_ctrl, checked against a
// stage-level behavioural model of the hazard rules.
module tb_pipeline_hazard_ctrl;
  localparam int CNT_W = 4;
  localparam int SAT   = (1 << CNT_W) - 1;
  localparam int M_RUN = 0, M_DWAIT = 1, M_DRAIN = 2, M_HALT = 3;

  logic CLK = 1'b0;
  logic nRST, ihit, dhit, dmemREN, dmemWEN, halt_EX_MEM, branch_taken_EX_MEM, dREN_ID_EX;
  logic [4:0] Rt_ID_EX, Rs_IF_ID, Rt_IF_ID;
  logic enable_PC, enable_IF_ID, flush_IF_ID, enable_ID_EX, flush_ID_EX;
  logic enable_EX_MEM, flush_EX_MEM, enable_MEM_WB, flush_MEM_WB, imemREN_gate, halt;
  logic [CNT_W-1:0] stall_cycles;

  int   errors = 0;
  int   checks = 0;
  int   mode;
  logic exp_halt;
  int   exp_stall;

  pipeline_hazard_ctrl #(.CNT_W(CNT_W)) dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .dmemREN(dmemREN), .dmemWEN(dmemWEN),
    .halt_EX_MEM(halt_EX_MEM), .branch_taken_EX_MEM(branch_taken_EX_MEM),
    .dREN_ID_EX(dREN_ID_EX), .Rt_ID_EX(Rt_ID_EX), .Rs_IF_ID(Rs_IF_ID), .Rt_IF_ID(Rt_IF_ID),
    .enable_PC(enable_PC), .enable_IF_ID(enable_IF_ID), .flush_IF_ID(flush_IF_ID),
    .enable_ID_EX(enable_ID_EX), .flush_ID_EX(flush_ID_EX),
    .enable_EX_MEM(enable_EX_MEM), .flush_EX_MEM(flush_EX_MEM),
    .enable_MEM_WB(enable_MEM_WB), .flush_MEM_WB(flush_MEM_WB),
    .imemREN_gate(imemREN_gate), .halt(halt), .stall_cycles(stall_cycles)
  );

  always #5 CLK = ~CLK;

  // Stage index 0=IF/ID 1=ID/EX 2=EX/MEM 3=MEM/WB; packed as {gate, pc, (en,fl) per stage}.
  function automatic logic [9:0] ref_ctrl();
    logic [3:0] en, fl;
    logic pc, gate, hazard, miss;
    en = 4'b1111; fl = 4'b0000; pc = 1'b1; gate = 1'b1;
    hazard = dREN_ID_EX && (Rt_ID_EX != 0) && (Rt_ID_EX == Rs_IF_ID || Rt_ID_EX == Rt_IF_ID);
    miss   = (dmemREN || dmemWEN) && !dhit;
    if (!nRST || mode == M_HALT) begin
      en = 4'b0000; fl = 4'b1111; pc = 1'b0; gate = 1'b0;
    end else if (mode == M_DRAIN) begin
      en = 4'b1000; fl = 4'b0111; pc = 1'b0; gate = 1'b0;
    end else if (mode == M_DWAIT) begin
      pc = 1'b0; gate = 1'b0;
      if (dhit) begin en = 4'b1100; fl = 4'b0100; end
      else      begin en = 4'b0000; fl = 4'b1000; end
    end else if (halt_EX_MEM) begin
      pc = 1'b0; fl = 4'b0111;
    end else if (miss) begin
      pc = 1'b0; en = 4'b0000; fl = 4'b1000; gate = 1'b0;
    end else if (branch_taken_EX_MEM && ihit) begin
      fl = 4'b0111;
    end else if (branch_taken_EX_MEM) begin
      pc = 1'b0; en[0] = 1'b0; en[2] = 1'b0; fl = 4'b1010;
    end else if (hazard || !ihit) begin
      pc = 1'b0; en[0] = 1'b0; fl[1] = 1'b1;
    end
    return {gate, pc, en[0], fl[0], en[1], fl[1], en[2], fl[2], en[3], fl[3]};
  endfunction

  function automatic logic [9:0] obs_ctrl();
    return {imemREN_gate, enable_PC, enable_IF_ID, flush_IF_ID, enable_ID_EX, flush_ID_EX,
            enable_EX_MEM, flush_EX_MEM, enable_MEM_WB, flush_MEM_WB};
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mode = M_RUN; exp_halt = 1'b0; exp_stall = 0;
  endtask

  // One clock: check at the falling edge, advance the model at the rising edge.
  task automatic step(input string tag);
    logic [9:0] e;
    int nxt;
    @(negedge CLK);
    e = ref_ctrl();
    chk({tag, "/ctrl"}, {6'd0, obs_ctrl()}, {6'd0, e});
    chk({tag, "/halt"}, {15'd0, halt}, {15'd0, exp_halt});
    chk({tag, "/stall"}, {12'd0, stall_cycles}, exp_stall[15:0]);
    @(posedge CLK);
    if (nRST) begin
      if (!e[8] && mode != M_HALT && exp_stall < SAT) exp_stall++;
      nxt = mode;
      case (mode)
        M_RUN:   if (halt_EX_MEM) nxt = M_DRAIN;
                 else if ((dmemREN || dmemWEN) && !dhit) nxt = M_DWAIT;
        M_DWAIT: if (dhit) nxt = M_RUN;
        M_DRAIN: begin nxt = M_HALT; exp_halt = 1'b1; end
        default: nxt = M_HALT;
      endcase
      mode = nxt;
    end else begin
      model_reset();
    end
    #1;
  endtask

  task automatic quiet();
    ihit = 1'b1; dhit = 1'b0; dmemREN = 1'b0; dmemWEN = 1'b0; halt_EX_MEM = 1'b0;
    branch_taken_EX_MEM = 1'b0; dREN_ID_EX = 1'b0; Rt_ID_EX = 0; Rs_IF_ID = 0; Rt_IF_ID = 0;
  endtask

  initial begin
    quiet();
    ihit = 1'b0;
    nRST = 1'b0;
    model_reset();
    #2;
    chk("reset/ctrl", {6'd0, obs_ctrl()}, {6'd0, ref_ctrl()});
    chk("reset/halt", {15'd0, halt}, 16'd0);
    chk("reset/stall", {12'd0, stall_cycles}, 16'd0);
    @(posedge CLK); #1;
    nRST = 1'b1;
    quiet();

    for (int i = 0; i < 10; i++) step("normal");
    chk("normal/stall0", {12'd0, stall_cycles}, 16'd0);

    dmemREN = 1'b1; dhit = 1'b0;
    for (int i = 0; i < 3; i++) step("dmiss");
    dhit = 1'b1;
    step("dhit");
    chk("dmem/stall4", {12'd0, stall_cycles}, 16'd4);
    quiet();
    step("after_dwait");

    dREN_ID_EX = 1'b1; Rt_ID_EX = 5'd5; Rs_IF_ID = 5'd5; Rt_IF_ID = 5'd9;
    step("loaduse_rs");
    Rs_IF_ID = 5'd3; Rt_IF_ID = 5'd5;
    step("loaduse_rt");
    Rt_ID_EX = 5'd0; Rs_IF_ID = 5'd0; Rt_IF_ID = 5'd0;
    step("loaduse_r0");
    quiet();

    branch_taken_EX_MEM = 1'b1;
    step("branch_hit");
    ihit = 1'b0;
    step("branch_hold1");
    step("branch_hold2");
    ihit = 1'b1;
    step("branch_release");
    quiet();

    ihit = 1'b0;
    for (int i = 0; i < SAT + 6; i++) step("sat");
    chk("sat/value", {12'd0, stall_cycles}, 16'd15);
    quiet();

    dmemWEN = 1'b1; dhit = 1'b0;
    step("dwait_enter");
    step("dwait_mid");
    #2;
    nRST = 1'b0;
    #1;
    model_reset();
    chk("async_rst/ctrl", {6'd0, obs_ctrl()}, {6'd0, ref_ctrl()});
    chk("async_rst/stall", {12'd0, stall_cycles}, 16'd0);
    step("rst_hold");
    nRST = 1'b1;
    quiet();
    step("rst_run");

    for (int i = 0; i < 300; i++) begin
      ihit                = ($urandom_range(0, 3) != 0);
      dhit                = ($urandom_range(0, 2) != 0);
      dmemREN             = ($urandom_range(0, 4) == 0);
      dmemWEN             = ($urandom_range(0, 6) == 0);
      branch_taken_EX_MEM = ($urandom_range(0, 5) == 0);
      dREN_ID_EX          = $urandom_range(0, 1) != 0;
      Rt_ID_EX            = 5'($urandom_range(0, 3));
      Rs_IF_ID            = 5'($urandom_range(0, 3));
      Rt_IF_ID            = 5'($urandom_range(0, 3));
      step("random");
    end
    quiet();
    while (mode != M_RUN) begin
      dhit = 1'b1;
      step("settle");
    end

    halt_EX_MEM = 1'b1;
    step("halt_mem");
    halt_EX_MEM = 1'b0;
    step("drain");
    for (int i = 0; i < 20; i++) begin
      ihit = $urandom_range(0, 1) != 0;
      branch_taken_EX_MEM = $urandom_range(0, 1) != 0;
      halt_EX_MEM = $urandom_range(0, 1) != 0;
      step("halted");
    end
    chk("halted/sticky", {15'd0, halt}, 16'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
